// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: divided up/down binary sequencer presented on a Gray-coded output,
// with oneshot (done pulse) or wrap (wrap pulse) modes. Defining GRAY_PAUSE_EN adds a pause input.
module gray_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
`ifdef GRAY_PAUSE_EN
  input  logic             pause,
`endif
  input  logic             dir,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] gray,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  localparam int              DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0]   DIV_ONE  = DW'(1);
  localparam logic [WIDTH-1:0] BIN_ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [DW-1:0]    div_q, div_d;
  logic             dir_q, dir_d;
  logic             oneshot_q, oneshot_d;
  logic             wrap_q, wrap_d;

  logic             pause_w;
  logic             tick;
  logic [WIDTH-1:0] terminal;
  logic [WIDTH-1:0] reload;

`ifdef GRAY_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  // Terminal and reload values swap roles with the captured direction.
  assign terminal = dir_q ? '0 : limit_q;
  assign reload   = dir_q ? limit_q : '0;
  assign tick     = (div_q == DIV_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bin_q     <= '0;
      limit_q   <= '0;
      div_q     <= '0;
      dir_q     <= 1'b0;
      oneshot_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      limit_q   <= limit_d;
      div_q     <= div_d;
      dir_q     <= dir_d;
      oneshot_q <= oneshot_d;
      wrap_q    <= wrap_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    limit_d   = limit_q;
    div_d     = div_q;
    dir_d     = dir_q;
    oneshot_d = oneshot_q;
    wrap_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d   = S_RUN;
          bin_d     = dir ? limit : '0;
          div_d     = '0;
          dir_d     = dir;
          oneshot_d = oneshot;
          limit_d   = limit;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (pause_w) begin
          state_d = S_PAUSE;
        end else begin
          div_d = tick ? '0 : div_q + DIV_ONE;
          if (tick) begin
            if (bin_q != terminal) begin
              bin_d = dir_q ? bin_q - BIN_ONE : bin_q + BIN_ONE;
            end else if (oneshot_q) begin
              state_d = S_DONE;
            end else begin
              bin_d  = reload;
              wrap_d = 1'b1;
            end
          end
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (!pause_w) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    gray = bin_q ^ (bin_q >> 1);
    busy = (state_q == S_RUN) || (state_q == S_PAUSE);
    done = (state_q == S_DONE);
    wrap = wrap_q;
  end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb_gray_seq_ctrl: directed bench for gray_seq_ctrl, one DIV=1 and one DIV=3 instance
// sharing stimulus; the pause scenario is included when GRAY_PAUSE_EN is defined.
module tb_gray_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       dir = 1'b0;
  logic       oneshot = 1'b0;
  logic [3:0] limit = 4'd0;
`ifdef GRAY_PAUSE_EN
  logic       pause = 1'b0;
`endif

  logic [3:0] gray1, gray3;
  logic       busy1, done1, wrap1;
  logic       busy3, done3, wrap3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gray_seq_ctrl #(.WIDTH(4), .DIV(1)) u_dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
`ifdef GRAY_PAUSE_EN
    .pause   (pause),
`endif
    .dir     (dir),
    .oneshot (oneshot),
    .limit   (limit),
    .gray    (gray1),
    .busy    (busy1),
    .done    (done1),
    .wrap    (wrap1)
  );

  gray_seq_ctrl #(.WIDTH(4), .DIV(3)) u_dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
`ifdef GRAY_PAUSE_EN
    .pause   (pause),
`endif
    .dir     (dir),
    .oneshot (oneshot),
    .limit   (limit),
    .gray    (gray3),
    .busy    (busy3),
    .done    (done3),
    .wrap    (wrap3)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic d, input logic o, input logic [3:0] l);
    start   = 1'b1;
    dir     = d;
    oneshot = o;
    limit   = l;
    step();
    start   = 1'b0;
  endtask

  task automatic idle_all();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  logic [3:0] exp_up5 [6] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111};
  logic [3:0] exp_dn3 [9] = '{4'b0010, 4'b0011, 4'b0001, 4'b0000, 4'b0010,
                              4'b0011, 4'b0001, 4'b0000, 4'b0010};
  logic       exp_wr3 [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [3:0] exp_div3 [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001,
                               4'b0001, 4'b0011, 4'b0011, 4'b0011};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-on reset
    step();
    step();
    check("rst_gray", gray1, 4'b0000);
    check("rst_busy", busy1, 1'b0);
    check("rst_done", done1, 1'b0);
    check("rst_wrap", wrap1, 1'b0);
    rst_n = 1'b1;
    step();

    // Up oneshot limit=5, DIV=1
    do_start(1'b0, 1'b1, 4'd5);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("up5_gray%0d", i), gray1, exp_up5[i]);
      check($sformatf("up5_busy%0d", i), busy1, 1'b1);
      check($sformatf("up5_done%0d", i), done1, 1'b0);
      step();
    end
    check("up5_done", done1, 1'b1);
    check("up5_done_busy", busy1, 1'b0);
    check("up5_done_gray", gray1, 4'b0111);
    step();
    check("up5_done_pulse", done1, 1'b0);
    check("up5_idle_gray", gray1, 4'b0111);
    idle_all();

    // Down wrap limit=3; captured config must ignore later input changes
    do_start(1'b1, 1'b0, 4'd3);
    dir     = 1'b0;
    oneshot = 1'b1;
    limit   = 4'd7;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("dn3_gray%0d", i), gray1, exp_dn3[i]);
      check($sformatf("dn3_wrap%0d", i), wrap1, exp_wr3[i]);
      check($sformatf("dn3_busy%0d", i), busy1, 1'b1);
      step();
    end
    check("dn3_pre_stop", gray1, 4'b0011);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_busy", busy1, 1'b0);
    check("stop_gray", gray1, 4'b0011);
    check("stop_done", done1, 1'b0);
    check("stop_wrap", wrap1, 1'b0);
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("startstop_busy", busy1, 1'b0);
    check("startstop_gray", gray1, 4'b0011);
    step();
    check("startstop_busy2", busy1, 1'b0);
    idle_all();

    // limit=0 boundaries
    do_start(1'b0, 1'b1, 4'd0);
    check("lim0os_gray", gray1, 4'b0000);
    check("lim0os_busy", busy1, 1'b1);
    step();
    check("lim0os_done", done1, 1'b1);
    check("lim0os_busy2", busy1, 1'b0);
    idle_all();
    idle_all();
    do_start(1'b0, 1'b0, 4'd0);
    check("lim0wr_wrap0", wrap1, 1'b0);
    step();
    check("lim0wr_wrap1", wrap1, 1'b1);
    check("lim0wr_gray", gray1, 4'b0000);
    check("lim0wr_busy", busy1, 1'b1);
    step();
    check("lim0wr_wrap2", wrap1, 1'b1);
    idle_all();

    // DIV=3 up oneshot limit=2
    do_start(1'b0, 1'b1, 4'd2);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("div3_gray%0d", i), gray3, exp_div3[i]);
      check($sformatf("div3_busy%0d", i), busy3, 1'b1);
      check($sformatf("div3_done%0d", i), done3, 1'b0);
      step();
    end
    check("div3_done", done3, 1'b1);
    check("div3_done_busy", busy3, 1'b0);
    check("div3_done_gray", gray3, 4'b0011);
    step();
    check("div3_done_pulse", done3, 1'b0);
    idle_all();

`ifdef GRAY_PAUSE_EN
    // Pause at gray=0001 on DIV=3 after one divider cycle has elapsed
    do_start(1'b0, 1'b0, 4'd3);
    step();
    step();
    step();
    check("pause_pre", gray3, 4'b0001);
    step();
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("pause_gray%0d", i), gray3, 4'b0001);
      check($sformatf("pause_busy%0d", i), busy3, 1'b1);
    end
    pause = 1'b0;
    step();
    check("resume_gray0", gray3, 4'b0001);
    step();
    check("resume_gray1", gray3, 4'b0001);
    step();
    check("resume_gray2", gray3, 4'b0011);
    idle_all();
`endif

    // Reset held two cycles mid-run overrides a concurrent start
    do_start(1'b0, 1'b0, 4'd5);
    step();
    step();
    check("mid_pre_busy", busy1, 1'b1);
    rst_n = 1'b0;
    start = 1'b1;
    step();
    check("midrst_gray", gray1, 4'b0000);
    check("midrst_busy", busy1, 1'b0);
    check("midrst_busy3", busy3, 1'b0);
    step();
    check("midrst_gray2", gray1, 4'b0000);
    check("midrst_done", done1, 1'b0);
    check("midrst_wrap", wrap1, 1'b0);
    rst_n = 1'b1;
    start = 1'b0;
    step();
    check("midrst_after_busy", busy1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_seq_ctrl.md
GRAY_SEQ_CTRL -- requirements
Module: gray_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter/Gray bit width (2..16).
REQ-002 SHALL have parameter DIV, default 1, clock cycles per count step (1..256).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  start sequence (acted on in IDLE only).
REQ-006 SHALL have port stop  input  1  abort sequence, return to IDLE.
REQ-007 SHALL have port dir  input  1  0 = count up, 1 = count down; sampled on accepted start.
REQ-008 SHALL have port oneshot  input  1  1 = stop at terminal, 0 = wrap; sampled on accepted start.
REQ-009 SHALL have port limit  input  WIDTH  binary terminal value; sampled on accepted start.
REQ-010 SHALL have port gray  output  WIDTH  Gray code of internal binary count, gray = bin ^ (bin >> 1).
REQ-011 SHALL have port busy  output  1  high in RUN or PAUSE.
REQ-012 SHALL have port done  output  1  one-cycle pulse on oneshot completion.
REQ-013 SHALL have port wrap  output  1  one-cycle pulse on each wrap reload.

Function
REQ-014 SHALL implement states IDLE, RUN, PAUSE, DONE; binary count bin, captured dir/oneshot/limit, divider counter.
REQ-015 IDLE + start (stop low): bin <= (dir ? limit : 0), divider cleared, capture dir/oneshot/limit, -> RUN; gray and busy reflect this in the next cycle.
REQ-016 tick = divider reached DIV-1 while in RUN; divider then clears, else increments; DIV=1 ticks every RUN cycle.
REQ-017 On tick with bin != terminal (limit if up, 0 if down): bin <= bin +1 (up) or -1 (down).
REQ-018 On tick with bin == terminal and oneshot: bin holds, -> DONE; done high during the single DONE cycle; DONE -> IDLE unconditionally.
REQ-019 On tick with bin == terminal and not oneshot: bin <= start value, wrap high the following cycle, stay RUN.
REQ-020 Each of limit+1 values SHALL be visible on gray for exactly DIV cycles per pass; limit=0 yields one value then done/wrap.
REQ-021 stop in RUN or PAUSE -> IDLE next cycle; bin and gray hold last value; no done or wrap.
REQ-022 start and stop same cycle in IDLE: stop wins, stay IDLE; start in RUN/PAUSE/DONE ignored.
REQ-023 Changes on dir/oneshot/limit during RUN/PAUSE SHALL be ignored.
REQ-024 gray SHALL change at most one bit per step, including at wrap reload only when start/terminal are Gray-adjacent (no guarantee otherwise).

Reset
REQ-025 rst_n low at a rising edge SHALL force IDLE, bin=0, divider=0, captured regs=0; gray=0, busy=0, done=0, wrap=0; overrides all other inputs, including mid-run.

Configuration
REQ-026 Macro GRAY_PAUSE_EN defined: input port pause (1 bit) exists; pause high in RUN -> PAUSE, bin and divider frozen; pause low in PAUSE -> RUN, divider resumes; stop beats pause; pause ignored in IDLE/DONE.
REQ-027 GRAY_PAUSE_EN undefined: pause port absent, PAUSE state unreachable, all else identical.

Verification
REQ-028 rst_n low 2 cycles mid-run -> gray=0000, busy=0, done=0, wrap=0 next cycle.
REQ-029 WIDTH=4, DIV=1, start dir=0 oneshot=1 limit=5 -> gray 0000,0001,0011,0010,0110,0111, then done=1 one cycle, busy=0, gray stays 0111.
REQ-030 dir=1 oneshot=0 limit=3 -> gray 0010,0011,0001,0000,0010 with wrap=1 on the second 0010, repeating.
REQ-031 stop at gray=0011 -> IDLE, gray holds 0011, done=0; start+stop same cycle in IDLE -> busy stays 0.
REQ-032 DIV=3, limit=2 up oneshot -> 0000,0001,0011 each held 3 cycles, then done.
REQ-033 GRAY_PAUSE_EN, pause 4 cycles at gray=0001 -> gray holds 0001, busy=1; resumes to 0011 after remaining divider cycles.
